cv_pattern_sched: RTL and testbench
===================================

Name: cv_pattern_sched

Overview:
- Frame-synchronous scheduler for the composite-video test pattern generators (checkers, bars, ramps, etc.).
- Enables exactly one generator at a time and muxes its 2-bit luminance onto the shared lum path feeding the video output stage.
- Switches patterns only at frame boundaries: automatically every N frames, or on a manual request with a req/ack handshake.

Parameters:
- NUM_PATTERNS, 4, number of pattern generators (2..8).
- FRAMES_PER_PATTERN, 50, frames each pattern is shown in auto mode (>=1).
- IDX_NOB, $clog2(NUM_PATTERNS), width of pattern index (derived localparam, not overridable).

Ports:
- clk  in  1  clock (rising edge)
- reset  in  1  asynchronous, active-high reset
- en  in  1  scheduler enable; low forces idle (synchronous)
- clk_en_pixel  in  1  pixel clock enable, one in every N clk
- frame_start  in  1  single-clk pulse at start of each frame (from cv timing)
- auto_en  in  1  auto-cycle enable
- lum_in  in  2*NUM_PATTERNS  packed generator outputs; pattern k at [2k+1:2k]
- sel_req  in  1  manual select request, one-clk pulse
- sel_idx  in  IDX_NOB  requested pattern, sampled with sel_req
- sel_busy  out  1  manual request pending; further sel_req ignored
- sel_ack  out  1  one-clk pulse when the requested switch takes effect
- sel_err  out  1  one-clk pulse: sel_req with sel_idx>=NUM_PATTERNS
- gen_en  out  NUM_PATTERNS  one-hot generator enables
- pat_idx  out  IDX_NOB  active pattern index
- lum  out  2  scheduled luminance (registered)

Behaviour:
- Reset (async): state=IDLE, pat_idx=0, gen_en=0, lum=0, sel_busy=0, sel_ack=0, sel_err=0, frame_cnt=0, pending request cleared. All outputs are registered.
- States:
  - IDLE: all outputs zero except pat_idx, which is held. en=1 -> ARM.
  - ARM: gen_en=0, lum=0. frame_start -> RUN, gen_en=onehot(pat_idx), frame_cnt=0.
  - RUN: normal operation.
  - BLANK: only with the optional feature.
- en=0 in any state -> IDLE on the next clk. frame_cnt and the pending request are cleared; pat_idx is kept.
- frame_cnt (width $clog2(FRAMES_PER_PATTERN)+1):
  - Increments on each frame_start in RUN.
  - Auto switch when auto_en=1 and frame_cnt==FRAMES_PER_PATTERN-1 at frame_start: pat_idx <= (pat_idx==NUM_PATTERNS-1) ? 0 : pat_idx+1, and frame_cnt <= 0.
  - auto_en=0: frame_cnt saturates at FRAMES_PER_PATTERN-1; no auto switch.
- Manual request:
  - sel_req is accepted in ARM/RUN/BLANK when sel_busy=0 and sel_idx<NUM_PATTERNS. The index is captured and sel_busy=1 on the next clk.
  - sel_idx out of range: no capture; sel_err pulses on the next clk.
  - sel_req while sel_busy=1 is ignored silently.
  - sel_req in IDLE is ignored.
- Switch timing:
  - A pending request applies at the first frame_start strictly after capture. A sel_req coincident with frame_start applies at the following frame_start.
  - On apply: pat_idx <= captured index, frame_cnt <= 0, sel_busy <= 0, and sel_ack pulses in the same clk.
  - Selecting the already-active index still acks and resets frame_cnt.
  - Manual beats auto when both are due at the same frame_start.
- gen_en updates in the same clk as pat_idx. It stays one-hot in RUN and is zero otherwise.
- lum:
  - Updates only when clk_en_pixel=1.
  - In RUN: lum <= lum_in[2*pat_idx+1 : 2*pat_idx]; otherwise 0.
  - Latency: one clk_en_pixel tick after the lum_in sample.
- After a switch, lum follows the new index from the next clk_en_pixel onward.

Optional Feature:
- Macro: CV_SCHED_BLANK_EN
- Defined:
  - Every switch (auto or manual) at frame_start goes RUN -> BLANK. pat_idx is updated immediately, gen_en=0, and lum is forced to 0 for one full frame.
  - The next frame_start -> RUN with gen_en=onehot(pat_idx) and frame_cnt=0. sel_ack pulses on entry to BLANK.
  - A new request captured during BLANK applies at the frame_start that exits BLANK: it returns to BLANK with the new index.
- Undefined: no BLANK state; switches are direct RUN -> RUN.

Test Plan:
- Reset mid-run: reset pulse asynchronous to clk while RUN with pat_idx=2 -> all outputs 0 and pat_idx=0 immediately, without waiting for a clk edge. After release with en=1, ARM; first frame_start -> gen_en=4'b0001.
- Auto cycle: FRAMES_PER_PATTERN=3, NUM_PATTERNS=4, auto_en=1, 13 frame_starts -> pat_idx sequence 0,0,0,1,1,1,2,2,2,3,3,3,0. No sel_ack.
- Manual handshake: sel_req with sel_idx=3 mid-frame -> sel_busy=1 next clk. A second sel_req with idx=1 is ignored. Next frame_start -> pat_idx=3, gen_en=4'b1000, single sel_ack pulse, sel_busy=0.
- Collision: auto due at the same frame_start as a pending manual idx=0 -> pat_idx=0 and frame_cnt=0; the auto increment is not applied.
- Error/edge:
  - NUM_PATTERNS=3 with sel_idx=3 -> sel_err pulse, sel_busy stays 0.
  - sel_req coincident with frame_start -> applied one frame later.
- Lum path: lum_in={2'b11,2'b10,2'b01,2'b00}, pat_idx=2, clk_en_pixel every 4 clk -> lum=2'b10, changing only on enable ticks. en=0 -> lum=0 and IDLE next clk. With CV_SCHED_BLANK_EN, one frame of lum=0 and gen_en=0 after each switch.

Source files
------------

// File: rtl/cv_pattern_sched.sv
// rtl/cv_pattern_sched.sv - frame-synchronous pattern generator scheduler and lum mux
// Optional one-frame blanking between patterns: define CV_SCHED_BLANK_EN
module cv_pattern_sched #(
   parameter int  NUM_PATTERNS       = 4,
   parameter int  FRAMES_PER_PATTERN = 50,
   localparam int IDX_NOB            = $clog2(NUM_PATTERNS)
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      en,
   input  logic                      clk_en_pixel,
   input  logic                      frame_start,
   input  logic                      auto_en,
   input  logic [2*NUM_PATTERNS-1:0] lum_in,
   input  logic                      sel_req,
   input  logic [IDX_NOB-1:0]        sel_idx,
   output logic                      sel_busy,
   output logic                      sel_ack,
   output logic                      sel_err,
   output logic [NUM_PATTERNS-1:0]   gen_en,
   output logic [IDX_NOB-1:0]        pat_idx,
   output logic [1:0]                lum
);

   typedef enum logic [1:0] {S_IDLE, S_ARM, S_RUN, S_BLANK} state_t;

   localparam int                 CNT_W    = $clog2(FRAMES_PER_PATTERN) + 1;
   localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(FRAMES_PER_PATTERN - 1);
   localparam logic [IDX_NOB-1:0] IDX_LAST = IDX_NOB'(NUM_PATTERNS - 1);

   state_t             state;
   logic [CNT_W-1:0]   frame_cnt;
   logic [IDX_NOB-1:0] req_idx;
   logic [IDX_NOB-1:0] auto_idx;
   logic [IDX_NOB-1:0] nxt_idx;
   logic [IDX_NOB:0]   lum_base;
   logic [31:0]        sel_idx_ext;
   logic               idx_ok;
   logic               cnt_last;
   logic               do_switch;

   function automatic logic [NUM_PATTERNS-1:0] onehot(input logic [IDX_NOB-1:0] i);
      onehot    = '0;
      onehot[i] = 1'b1;
   endfunction

   assign auto_idx    = (pat_idx == IDX_LAST) ? '0 : pat_idx + 1'b1;
   assign sel_idx_ext = 32'(sel_idx);
   assign idx_ok      = sel_idx_ext < 32'(NUM_PATTERNS);
   assign cnt_last    = (frame_cnt == CNT_LAST);
   assign lum_base    = {pat_idx, 1'b0};

   // A pending manual request takes priority over an auto switch due on the same frame.
   always_comb begin
      do_switch = 1'b0;
      nxt_idx   = pat_idx;
      if (frame_start && sel_busy) begin
         do_switch = 1'b1;
         nxt_idx   = req_idx;
      end else if (frame_start && auto_en && cnt_last) begin
         do_switch = 1'b1;
         nxt_idx   = auto_idx;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= S_IDLE;
         pat_idx   <= '0;
         gen_en    <= '0;
         lum       <= '0;
         sel_busy  <= 1'b0;
         sel_ack   <= 1'b0;
         sel_err   <= 1'b0;
         frame_cnt <= '0;
         req_idx   <= '0;
      end else begin
         sel_ack <= 1'b0;
         sel_err <= 1'b0;
         if (!en) begin
            state     <= S_IDLE;
            gen_en    <= '0;
            lum       <= '0;
            sel_busy  <= 1'b0;
            frame_cnt <= '0;
         end else begin
            if (state != S_IDLE && sel_req && !sel_busy) begin
               if (idx_ok) begin
                  sel_busy <= 1'b1;
                  req_idx  <= sel_idx;
               end else begin
                  sel_err <= 1'b1;
               end
            end
            if (clk_en_pixel)
               lum <= (state == S_RUN) ? lum_in[lum_base +: 2] : 2'b00;
            case (state)
               S_IDLE: state <= S_ARM;
               S_ARM: if (frame_start) begin
                  state     <= S_RUN;
                  frame_cnt <= '0;
                  if (sel_busy) begin
                     pat_idx  <= req_idx;
                     gen_en   <= onehot(req_idx);
                     sel_ack  <= 1'b1;
                     sel_busy <= 1'b0;
                  end else begin
                     gen_en <= onehot(pat_idx);
                  end
               end
               S_RUN: if (frame_start) begin
                  if (do_switch) begin
                     pat_idx   <= nxt_idx;
                     frame_cnt <= '0;
                     sel_ack   <= sel_busy;
                     if (sel_busy) sel_busy <= 1'b0;
`ifdef CV_SCHED_BLANK_EN
                     state  <= S_BLANK;
                     gen_en <= '0;
                     lum    <= '0;
`else
                     gen_en <= onehot(nxt_idx);
`endif
                  end else if (!cnt_last) begin
                     frame_cnt <= frame_cnt + 1'b1;
                  end
               end
`ifdef CV_SCHED_BLANK_EN
               // A request captured while blanked restarts the blank with the new index.
               S_BLANK: if (frame_start) begin
                  frame_cnt <= '0;
                  if (sel_busy) begin
                     pat_idx  <= req_idx;
                     sel_ack  <= 1'b1;
                     sel_busy <= 1'b0;
                  end else begin
                     state  <= S_RUN;
                     gen_en <= onehot(pat_idx);
                  end
               end
`endif
               default: state <= S_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_cv_pattern_sched.sv
// tb/tb_cv_pattern_sched.sv - scoreboard bench for cv_pattern_sched (default build)
module tb_cv_pattern_sched;

   typedef struct packed {
      logic [1:0] idx;
      logic [3:0] gen;
      logic       ack;
      logic       busy;
   } frame_t;

   typedef struct packed {
      logic busy;
      logic err;
   } req_t;

   logic       clk = 1'b0;
   logic       reset, en, clk_en_pixel, frame_start, auto_en;
   logic       sel_req, sel_req3, lum_phase;
   logic [7:0] lum_in;
   logic [1:0] sel_idx;

   logic       sel_busy, sel_ack, sel_err;
   logic [3:0] gen_en;
   logic [1:0] pat_idx, lum;
   logic       sel_busy3, sel_ack3, sel_err3;
   logic [2:0] gen_en3;
   logic [1:0] pat_idx3, lum3;

   frame_t     fq[$];
   req_t       rq[$];
   req_t       rq3[$];
   logic [1:0] lq[$];

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   cv_pattern_sched #(.NUM_PATTERNS(4), .FRAMES_PER_PATTERN(3)) dut (
      .clk(clk), .reset(reset), .en(en), .clk_en_pixel(clk_en_pixel),
      .frame_start(frame_start), .auto_en(auto_en), .lum_in(lum_in),
      .sel_req(sel_req), .sel_idx(sel_idx), .sel_busy(sel_busy), .sel_ack(sel_ack),
      .sel_err(sel_err), .gen_en(gen_en), .pat_idx(pat_idx), .lum(lum));

   cv_pattern_sched #(.NUM_PATTERNS(3), .FRAMES_PER_PATTERN(3)) dut3 (
      .clk(clk), .reset(reset), .en(en), .clk_en_pixel(clk_en_pixel),
      .frame_start(frame_start), .auto_en(auto_en), .lum_in(lum_in[5:0]),
      .sel_req(sel_req3), .sel_idx(sel_idx), .sel_busy(sel_busy3), .sel_ack(sel_ack3),
      .sel_err(sel_err3), .gen_en(gen_en3), .pat_idx(pat_idx3), .lum(lum3));

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, required %0h", nm, act, exp);
      end
   endtask

   function automatic logic [3:0] oh(input int i);
      oh = 4'b0001 << i;
   endfunction

   // Monitor: responses are due on the negedge after the triggering posedge.
   logic fs_q = 1'b0, rq_q = 1'b0, rq3_q = 1'b0, lp_q = 1'b0;
   always @(posedge clk) begin
      fs_q  <= frame_start;
      rq_q  <= sel_req;
      rq3_q <= sel_req3;
      lp_q  <= lum_phase;
   end

   always @(negedge clk) begin
      frame_t     f;
      req_t       r;
      logic [1:0] l;
      if (fs_q) begin
         if (fq.size() == 0) begin
            n_err++;
            $display("FAIL frame_q: frame response with empty expectation queue");
         end else begin
            f = fq.pop_front();
            chk("frame pat_idx", 32'(pat_idx), 32'(f.idx));
            chk("frame gen_en", 32'(gen_en), 32'(f.gen));
            chk("frame sel_ack", 32'(sel_ack), 32'(f.ack));
            chk("frame sel_busy", 32'(sel_busy), 32'(f.busy));
         end
      end else if (sel_ack !== 1'b0) begin
         n_err++;
         $display("FAIL sel_ack: got %b away from frame_start, required 0", sel_ack);
      end
      if (rq_q) begin
         if (rq.size() == 0) begin
            n_err++;
            $display("FAIL req_q: request response with empty expectation queue");
         end else begin
            r = rq.pop_front();
            chk("req sel_busy", 32'(sel_busy), 32'(r.busy));
            chk("req sel_err", 32'(sel_err), 32'(r.err));
         end
      end else if (sel_err !== 1'b0) begin
         n_err++;
         $display("FAIL sel_err: got %b without request, required 0", sel_err);
      end
      if (rq3_q) begin
         if (rq3.size() == 0) begin
            n_err++;
            $display("FAIL req3_q: request response with empty expectation queue");
         end else begin
            r = rq3.pop_front();
            chk("req3 sel_busy", 32'(sel_busy3), 32'(r.busy));
            chk("req3 sel_err", 32'(sel_err3), 32'(r.err));
         end
      end else if (sel_err3 !== 1'b0 || sel_ack3 !== 1'b0) begin
         n_err++;
         $display("FAIL dut3 pulses: err=%b ack=%b, required 0 0", sel_err3, sel_ack3);
      end
      if (lp_q) begin
         if (lq.size() == 0) begin
            n_err++;
            $display("FAIL lum_q: lum sample with empty expectation queue");
         end else begin
            l = lq.pop_front();
            chk("lum", 32'(lum), 32'(l));
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
      frame_start = 1'b0;
      sel_req     = 1'b0;
      sel_req3    = 1'b0;
      lum_phase   = 1'b0;
   endtask

   task automatic frame(input logic [1:0] idx, input logic [3:0] gen,
                        input logic ack, input logic busy);
      frame_start = 1'b1;
      fq.push_back('{idx, gen, ack, busy});
      step(); step(); step();
   endtask

   task automatic req(input logic [1:0] idx, input logic busy, input logic err);
      sel_idx = idx;
      sel_req = 1'b1;
      rq.push_back('{busy, err});
      step(); step();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: bench did not reach its summary");
      $fatal(1, "watchdog");
   end

   initial begin
      int         seq [13] = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 0};
      logic [1:0] tv  [4]  = '{2'b10, 2'b10, 2'b11, 2'b01};
      logic [1:0] fld;

      reset = 1'b1; en = 1'b0; clk_en_pixel = 1'b0; frame_start = 1'b0;
      auto_en = 1'b0; sel_req = 1'b0; sel_req3 = 1'b0; lum_phase = 1'b0;
      lum_in = 8'h00; sel_idx = 2'd0;
      step(); step();
      chk("reset pat_idx", 32'(pat_idx), 0);
      chk("reset gen_en", 32'(gen_en), 0);
      chk("reset lum", 32'(lum), 0);
      chk("reset sel_busy", 32'(sel_busy), 0);
      chk("reset sel_ack", 32'(sel_ack), 0);
      chk("reset sel_err", 32'(sel_err), 0);
      chk("reset dut3 pat_idx", 32'(pat_idx3), 0);
      chk("reset dut3 gen_en", 32'(gen_en3), 0);
      chk("reset dut3 lum", 32'(lum3), 0);

      // Auto cycle through all four patterns, three frames each
      reset = 1'b0; en = 1'b1; auto_en = 1'b1;
      step(); step();
      for (int i = 0; i < 13; i++)
         frame(2'(seq[i]), oh(seq[i]), 1'b0, 1'b0);

      // Manual handshake; the second request is ignored while busy
      req(2'd3, 1'b1, 1'b0);
      req(2'd1, 1'b1, 1'b0);
      frame(2'd3, 4'b1000, 1'b1, 1'b0);

      // Collision: manual idx 0 wins over auto 0->1 and restarts the frame count
      frame(2'd3, 4'b1000, 1'b0, 1'b0);
      frame(2'd3, 4'b1000, 1'b0, 1'b0);
      frame(2'd0, 4'b0001, 1'b0, 1'b0);
      frame(2'd0, 4'b0001, 1'b0, 1'b0);
      frame(2'd0, 4'b0001, 1'b0, 1'b0);
      req(2'd0, 1'b1, 1'b0);
      frame(2'd0, 4'b0001, 1'b1, 1'b0);
      frame(2'd0, 4'b0001, 1'b0, 1'b0);
      frame(2'd0, 4'b0001, 1'b0, 1'b0);
      frame(2'd1, 4'b0010, 1'b0, 1'b0);

      // Request coincident with frame_start lands one frame later
      sel_idx = 2'd2;
      sel_req = 1'b1;
      rq.push_back('{1'b1, 1'b0});
      frame(2'd1, 4'b0010, 1'b0, 1'b1);
      frame(2'd2, 4'b0100, 1'b1, 1'b0);

      // Out-of-range index on the three-pattern instance
      sel_idx  = 2'd3;
      sel_req3 = 1'b1;
      rq3.push_back('{1'b0, 1'b1});
      step(); step();

      // Lum path on pattern 2; off-tick cycles present a different value
      for (int c = 0; c < 16; c++) begin
         clk_en_pixel = (c % 4 == 0);
         fld          = clk_en_pixel ? tv[c/4] : tv[c/4] ^ 2'b11;
         lum_in       = {2'b11, fld, 2'b01, 2'b00};
         lum_phase    = 1'b1;
         lq.push_back(tv[c/4]);
         step();
      end

      // en low forces IDLE and zero lum in one clk even on a pixel tick
      en = 1'b0; clk_en_pixel = 1'b1; lum_in = 8'b11_10_01_00;
      lum_phase = 1'b1;
      lq.push_back(2'b00);
      frame(2'd2, 4'b0000, 1'b0, 1'b0);
      sel_idx = 2'd3; sel_req = 1'b1; sel_req3 = 1'b1;
      rq.push_back('{1'b0, 1'b0});
      rq3.push_back('{1'b0, 1'b0});
      step(); step();

      // Asynchronous reset mid-run with pattern 2 active and a request pending
      en = 1'b1;
      step(); step();
      frame(2'd2, 4'b0100, 1'b0, 1'b0);
      lum_phase = 1'b1;
      lq.push_back(2'b10);
      req(2'd3, 1'b1, 1'b0);
      #2;
      reset = 1'b1;
      #1;
      chk("async reset pat_idx", 32'(pat_idx), 0);
      chk("async reset gen_en", 32'(gen_en), 0);
      chk("async reset lum", 32'(lum), 0);
      chk("async reset sel_busy", 32'(sel_busy), 0);
      step();
      reset = 1'b0;
      step(); step();
      frame(2'd0, 4'b0001, 1'b0, 1'b0);

      step(); step();
      chk("frame_q drained", fq.size(), 0);
      chk("req_q drained", rq.size(), 0);
      chk("req3_q drained", rq3.size(), 0);
      chk("lum_q drained", lq.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
